counter_arbiter: RTL

- Shares one BITS-wide cycle counter among NUM_REQ requesters.
- Each requester asks for a run of a given length. The arbiter picks one requester, then counts through Idle → Count → Finished, holding a one-hot grant for the whole run.
- It pulses a per-requester done flag when the run ends.
- It sits between client state machines that need timed wait intervals and the single shared counter datapath.

---
 rtl/counter_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter
// ---------------
// Shares one BITS-wide cycle counter among NUM_REQ requesters. A winner is
// chosen in Idle, its run length is latched, and the counter steps from 0 up
// to that length while a one-hot grant is held. A one-cycle done pulse
// follows, and the arbiter returns to Idle.
//
// Winner selection:
//   COUNTER_ARBITER_ROUNDROBIN_EN defined   : the search starts at the
//                                             round-robin pointer and wraps.
//   COUNTER_ARBITER_ROUNDROBIN_EN undefined : fixed priority, lowest index
//                                             wins. The pointer is still
//                                             maintained but not used.
//
// Ports
//   in_clk        clock, all state changes on the rising edge
//   in_rst        synchronous active-high reset
//   in_req        per-requester level request
//   in_len        packed run lengths, requester i at [i*BITS +: BITS]
//   out_grant     one-hot owner of the counter, zero when no owner
//   out_done      one-cycle completion pulse to the owner
//   out_busy      high while the arbiter is not Idle
//   out_ctr       current counter value
//   out_dbg_state FSM state (0 Idle, 1 Count, 2 Finished)
//   out_dbg_ptr   round-robin pointer
//
// Handshake: in_req is a level request with no ready/ack of its own. It is
// accepted on a rising edge where the arbiter is Idle and the requester wins;
// out_grant rising is the acknowledgement. Dropping in_req after that does
// not abort the run, and in_len is ignored once latched. A request still
// held after the done pulse is treated as a fresh request in the next Idle.

module counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BITS    = 8
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [NUM_REQ-1:0]          in_req,
  input  logic [NUM_REQ*BITS-1:0]     in_len,
  output logic [NUM_REQ-1:0]          out_grant,
  output logic [NUM_REQ-1:0]          out_done,
  output logic                        out_busy,
  output logic [BITS-1:0]             out_ctr,
  output logic [1:0]                  out_dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]  out_dbg_ptr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNT    = 2'd1,
    S_FINISHED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BITS-1:0]    ctr_q, ctr_d;
  logic [BITS-1:0]    len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   winner;
  logic               any_req;

  assign any_req = |in_req;

  // Winner selection. Both loops walk from the far end back toward the
  // preferred start, so the last assignment (closest to the start) wins.
  always_comb begin
    winner = '0;
`ifdef COUNTER_ARBITER_ROUNDROBIN_EN
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (in_req[cand]) begin
        winner = cand;
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        winner = IDX_W'(i);
      end
    end
`endif
  end

  // State register: every flop in the block, including the registered outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_COUNT;
          idx_d   = winner;
          len_d   = in_len[winner*BITS +: BITS];
          ctr_d   = '0;
        end
      end
      S_COUNT: begin
        // Stopping at equality means the all-ones length ends at all-ones
        // and the counter never wraps.
        if (ctr_q == len_q) begin
          state_d = S_FINISHED;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      S_FINISHED: begin
        state_d = S_IDLE;
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: decoded from the next state so that the output flops line
  // up with the state they describe.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_COUNT) begin
      grant_d[idx_d] = 1'b1;
    end
    if (state_d == S_FINISHED) begin
      done_d[idx_d] = 1'b1;
    end
  end

  assign out_grant     = grant_q;
  assign out_done      = done_q;
  assign out_busy      = busy_q;
  assign out_ctr       = ctr_q;
  assign out_dbg_state = state_q;
  assign out_dbg_ptr   = ptr_q;

endmodule
